btc_header_wb_master: RTL
=========================

Name: btc_header_wb_master

Overview:
Wishbone classic master that drives the miner's Wishbone slave port, the opposite end of the header-load protocol. On a start pulse it latches a 608-bit header (19 words; the nonce word is owned by the miner) and writes it as 19 single-beat writes. It then reads back one result word and reports done, or err on a bus timeout. Used as the on-chip or bench-side initiator for the block-header loader.

Parameters:
BITS, 32, data/address word width
HDR_WORDS, 19, number of header words written per job
BASE_ADR, 32'h3000_0000, address of header word 0
RESULT_OFS, 32'h0000_0080, byte offset of the result word read after the header
TIMEOUT, 255, maximum cycles stb may wait for ack before abort (8-bit counter)

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
start  in  1  job request, sampled only in IDLE
header  in  BITS*HDR_WORDS  header data; word n = header[BITS*n +: BITS]
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_we_o  out  1  1 = write
wbm_sel_o  out  4  byte selects
wbm_adr_o  out  32  byte address
wbm_dat_o  out  BITS  write data
wbm_dat_i  in  BITS  read data
wbm_ack_i  in  1  slave acknowledge
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse; result valid
err  out  1  sticky timeout flag, cleared by the next accepted start
result  out  BITS  last read word; held until overwritten

Behaviour:
- Reset: one clock of wb_rst_i high. All outputs are 0, state is IDLE, the word index is 0 and the timeout counter is 0. Reset mid-transaction drops cyc/stb on the same edge, and no partial done is produced.
- States: IDLE, WR, WR_GAP, RD, DONE.
- IDLE:
  - On start=1, latch header into an internal register, clear err, set idx=0 and go to WR.
  - A start seen in any other state is ignored.
- WR:
  - Drive cyc=stb=we=1, sel=4'hF, adr=BASE_ADR+4*idx, dat=hdr[BITS*idx +: BITS].
  - On ack=1: drop cyc/stb/we at that edge, go to WR_GAP and clear the timeout counter.
- WR_GAP:
  - One cycle with cyc=stb=0. This is required because the slave acks on valid && !ready.
  - If idx==HDR_WORDS-1, go to RD; otherwise increment idx and go to WR.
- RD:
  - Drive cyc=stb=1, we=0, sel=4'hF, adr=BASE_ADR+RESULT_OFS, dat=0.
  - On ack: capture wbm_dat_i into result, drop cyc/stb and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Timeout:
  - In WR or RD, the counter increments each cycle ack=0.
  - When the counter reaches TIMEOUT with ack still 0: drop cyc/stb, set err=1, go to IDLE, and do not pulse done.
  - An ack in the same cycle the counter hits TIMEOUT wins (the transfer completes).
- Outside WR/RD, ack is ignored: no state change and result is not written.
- Addresses use 32-bit wrap-around arithmetic.
- Header latching: the internal header register is written only on an accepted start. Changing header mid-job has no effect.
- Latency with a slave that registers ack one cycle after stb:
  - Each write takes 3 cycles (stb, ack, gap).
  - Start sampled at edge 0; the first stb is visible after edge 0.
  - The read ack is sampled at edge 59, and done is high for the cycle after edge 59.
  - With a combinational ack, each write takes 2 cycles.

Decomposition:
- Package btc_pkg holds:
  - the state enum wbm_state_t (IDLE, WR, WR_GAP, RD, DONE);
  - localparams HDR_WORDS=19, NONCE_WORD=19, RESULT_OFS and BASE_ADR defaults;
  - a function word_adr(idx) returning BASE_ADR+4*idx.
- Single flat module; the timeout counter is too small to justify a sub-module.

Test Plan:
- Registered-ack responder model, header words = 32'h1000_0000+n, result = 32'hCAFE_F00D -> 19 writes at addresses 0x3000_0000..0x3000_0048 in order with matching data; one read at 0x3000_0080; result=CAFEF00D; done pulses once, in the cycle after edge 59.
- Combinational-ack responder -> each write takes 2 cycles; cyc is low for exactly one cycle between beats; done pulses once.
- Responder never acks word 5 -> stb is held for 255 cycles, then cyc=stb=0, err=1, busy=0 and no done. A following start clears err and completes normally.
- start held high for the whole job plus extra pulses while busy -> exactly one job. A second job starts only from IDLE, on the cycle after done.
- wb_rst_i asserted for 1 cycle during write 10 -> all outputs 0 on the next cycle and state IDLE. A new start re-sends from word 0.
- Spurious ack during WR_GAP and in IDLE -> no index advance and result unchanged. Ack arriving on the exact TIMEOUT cycle -> transfer completes with err=0.

Source files
------------

// File: rtl/btc_pkg.sv
// Shared types and defaults for the block-header Wishbone loader.
package btc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WR_GAP = 3'd2,
        RD     = 3'd3,
        DONE   = 3'd4
    } wbm_state_t;

    localparam int          HDR_WORDS  = 19;
    localparam int          NONCE_WORD = 19;
    localparam logic [31:0] BASE_ADR   = 32'h3000_0000;
    localparam logic [31:0] RESULT_OFS = 32'h0000_0080;

    // Byte address of header word idx; 32-bit wrap-around is intended.
    function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/btc_header_wb_master.sv
// Wishbone classic master: writes a latched block header word by word into the
// miner's slave port, then reads back one result word.
module btc_header_wb_master
    import btc_pkg::*;
#(
    parameter int          BITS       = 32,
    parameter int          HDR_WORDS  = btc_pkg::HDR_WORDS,
    parameter logic [31:0] BASE_ADR   = btc_pkg::BASE_ADR,
    parameter logic [31:0] RESULT_OFS = btc_pkg::RESULT_OFS,
    parameter int          TIMEOUT    = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start,
    input  logic [BITS*HDR_WORDS-1:0] header,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic                      wbm_we_o,
    output logic [3:0]                wbm_sel_o,
    output logic [31:0]               wbm_adr_o,
    output logic [BITS-1:0]           wbm_dat_o,
    input  logic [BITS-1:0]           wbm_dat_i,
    input  logic                      wbm_ack_i,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [BITS-1:0]           result
);

    localparam int               IDX_W    = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);
    // Abort on the last permitted wait cycle so stb is seen for exactly TIMEOUT cycles.
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

    wbm_state_t                state_r, state_next_s;
    logic [IDX_W-1:0]          idx_r, idx_next_s;
    logic [7:0]                cnt_r, cnt_next_s;
    logic [BITS*HDR_WORDS-1:0] hdr_r, hdr_next_s;
    logic                      err_next_s;
    logic                      res_load_s;
    logic                      cyc_s, stb_s, we_s;
    logic [3:0]                sel_s;
    logic [31:0]               adr_s;
    logic [BITS-1:0]           dat_s;

    // State register with job index, wait counter and latched header.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= 8'd0;
            hdr_r   <= {(BITS*HDR_WORDS){1'b0}};
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            cnt_r   <= cnt_next_s;
            hdr_r   <= hdr_next_s;
        end
    end

    // Next-state logic; an ack on the final wait cycle still completes the transfer.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        cnt_next_s   = cnt_r;
        hdr_next_s   = hdr_r;
        err_next_s   = err;
        res_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = WR;
                    idx_next_s   = {IDX_W{1'b0}};
                    cnt_next_s   = 8'd0;
                    hdr_next_s   = header;
                    err_next_s   = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR: begin
                if (wbm_ack_i) begin
                    state_next_s = WR_GAP;
                    cnt_next_s   = 8'd0;
                end else if (cnt_r == TO_LAST) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 8'd0;
                    err_next_s   = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + 8'd1;
                end
            end
            WR_GAP: begin
                cnt_next_s = 8'd0;
                if (idx_r == LAST_IDX) begin
                    state_next_s = RD;
                end else begin
                    state_next_s = WR;
                    idx_next_s   = idx_r + IDX_W'(1);
                end
            end
            RD: begin
                if (wbm_ack_i) begin
                    state_next_s = DONE;
                    cnt_next_s   = 8'd0;
                    res_load_s   = 1'b1;
                end else if (cnt_r == TO_LAST) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 8'd0;
                    err_next_s   = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + 8'd1;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Bus outputs decoded from the upcoming state so the registered copies track it.
    always_comb begin
        cyc_s = 1'b0;
        stb_s = 1'b0;
        we_s  = 1'b0;
        sel_s = 4'h0;
        adr_s = 32'h0000_0000;
        dat_s = {BITS{1'b0}};
        case (state_next_s)
            WR: begin
                cyc_s = 1'b1;
                stb_s = 1'b1;
                we_s  = 1'b1;
                sel_s = 4'hF;
                adr_s = word_adr(BASE_ADR, 32'(idx_next_s));
                dat_s = hdr_next_s[BITS*idx_next_s +: BITS];
            end
            RD: begin
                cyc_s = 1'b1;
                stb_s = 1'b1;
                sel_s = 4'hF;
                adr_s = BASE_ADR + RESULT_OFS;
            end
            default: begin
                cyc_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset drops the bus and suppresses any pending done.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0000_0000;
            wbm_dat_o <= {BITS{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= {BITS{1'b0}};
        end else begin
            wbm_cyc_o <= cyc_s;
            wbm_stb_o <= stb_s;
            wbm_we_o  <= we_s;
            wbm_sel_o <= sel_s;
            wbm_adr_o <= adr_s;
            wbm_dat_o <= dat_s;
            busy      <= (state_next_s != IDLE);
            done      <= (state_next_s == DONE);
            err       <= err_next_s;
            if (res_load_s) begin
                result <= wbm_dat_i;
            end else begin
                result <= result;
            end
        end
    end

endmodule
